// File: rtl/cache_ahb_mem_bridge.sv
// cache_ahb_mem_bridge: AHB-Lite slave bridging the cache backing-store path to a ready/strobe memory port.
// Latency: reads start combinationally in the address phase (zero-wait when memory is ready); writes issue in the data phase.
// Backpressure: HREADYOUT follows i_mem_ready while a command is outstanding; strobes are held until i_mem_ready.
// Optional build macro CACHE_AHB_ERR_CHECK_EN: misaligned or over-wide transfers get a two-cycle ERROR response.
module cache_ahb_mem_bridge #(
  parameter  int DATA_W     = 32,
  parameter  int ADDR_W     = 32,
  localparam int BE_W       = DATA_W / 8,
  localparam int MEM_ADDR_W = ADDR_W - $clog2(DATA_W / 8)
) (
  input  logic                  i_hclk,
  input  logic                  i_hnreset,
  input  logic                  i_hsel,
  input  logic [ADDR_W-1:0]     i_haddr,
  input  logic                  i_hwrite,
  input  logic [2:0]            i_hsize,
  input  logic [2:0]            i_hburst,
  input  logic [3:0]            i_hprot,
  input  logic [1:0]            i_htrans,
  input  logic                  i_hready,
  input  logic [DATA_W-1:0]     i_hwdata,
  output logic                  o_hready,
  output logic                  o_hresp,
  output logic [DATA_W-1:0]     o_hrdata,
  output logic [3:0]            o_hprot,
  input  logic                  i_mem_ready,
  input  logic [DATA_W-1:0]     i_mem_rdata,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  output logic                  o_mem_wr,
  output logic [BE_W-1:0]       o_mem_be,
  output logic [DATA_W-1:0]     o_mem_wdata
);

  localparam int OFF_W = $clog2(BE_W);
  localparam int PW    = 2 * BE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE
`ifdef CACHE_AHB_ERR_CHECK_EN
    ,
    S_ERR1,
    S_ERR2
`endif
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [2:0]          r_size;
  logic [3:0]          r_hprot;

  logic                w_request;
  logic                w_accept;
  logic                w_hready;
  logic                w_addr_ph;
  logic                w_start_rd;
  logic                w_err;
  state_t              w_acc_state;
  logic                w_unused;

  // Byte lanes touched by a transfer of size s at lane offset off; oversize covers the whole bus.
  function automatic logic [BE_W-1:0] f_be(input logic [2:0] s, input logic [OFF_W-1:0] off);
    logic [PW-1:0] m;
    m = '1;
    if (s <= 3'(OFF_W)) begin
      m = (PW'(1) << (1 << s)) - PW'(1);
      m = m << off;
    end
    return m[BE_W-1:0];
  endfunction

  // Burst type and the SEQ/NONSEQ distinction do not change how a beat is handled.
  assign w_unused = ^{i_hburst, i_htrans[0]};

  // Requests are ignored while reset is asserted so every output holds its reset value.
  assign w_request  = i_hsel & i_htrans[1] & i_hready & i_hnreset;
  assign w_accept   = w_request & w_hready;
  assign w_addr_ph  = (r_state == S_IDLE) & w_request;
  assign w_start_rd = w_addr_ph & ~i_hwrite & ~w_err;

`ifdef CACHE_AHB_ERR_CHECK_EN
  logic [OFF_W-1:0] w_align_mask;
  assign w_align_mask = OFF_W'((32'd1 << i_hsize) - 32'd1);
  assign w_err = (i_hsize > 3'(OFF_W)) | ((i_haddr[OFF_W-1:0] & w_align_mask) != '0);
  assign o_hresp = (r_state == S_ERR1) | (r_state == S_ERR2);
`else
  assign w_err   = 1'b0;
  assign o_hresp = 1'b0;
`endif

  // HREADYOUT: free when idle, follows memory completion while a command is outstanding.
  always_comb begin
    w_hready = 1'b1;
    case (r_state)
      S_READ, S_WRITE: w_hready = i_mem_ready;
`ifdef CACHE_AHB_ERR_CHECK_EN
      S_ERR1:          w_hready = 1'b0;
`endif
      default:         w_hready = 1'b1;
    endcase
  end

  // Destination state for a transfer accepted this cycle.
  always_comb begin
    w_acc_state = i_hwrite ? S_WRITE : S_READ;
`ifdef CACHE_AHB_ERR_CHECK_EN
    if (w_err) begin
      w_acc_state = S_ERR1;
    end
`endif
  end

  // Transfer FSM: latch the address phase on accept, fall back to idle once the data phase completes.
  always_ff @(posedge i_hclk or negedge i_hnreset) begin
    if (!i_hnreset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_size  <= '0;
      r_hprot <= '0;
    end else if (w_accept) begin
      r_state <= w_acc_state;
      r_addr  <= i_haddr;
      r_size  <= i_hsize;
      r_hprot <= i_hprot;
`ifdef CACHE_AHB_ERR_CHECK_EN
    end else if (r_state == S_ERR1) begin
      r_state <= S_ERR2;
`endif
    end else if (w_hready) begin
      r_state <= S_IDLE;
    end
  end

  // Memory command: reads may start from the live address phase, everything else uses latched fields.
  assign o_mem_rd    = (r_state == S_READ) | w_start_rd;
  assign o_mem_wr    = (r_state == S_WRITE);
  assign o_mem_addr  = w_addr_ph ? i_haddr[ADDR_W-1:OFF_W] : r_addr[ADDR_W-1:OFF_W];
  assign o_mem_be    = o_mem_wr ? f_be(r_size, r_addr[OFF_W-1:0]) : (o_mem_rd ? '1 : '0);
  assign o_mem_wdata = o_mem_wr ? i_hwdata : '0;

  // Bus response side.
  assign o_hready = w_hready;
  assign o_hrdata = ((r_state == S_READ) & i_mem_ready) ? i_mem_rdata : '0;
  assign o_hprot  = w_addr_ph ? i_hprot : r_hprot;

endmodule

// File: tb/tb_cache_ahb_mem_bridge.sv
// Testbench for cache_ahb_mem_bridge: directed scenarios plus a randomized pipelined master
// checked against a byte-lane memory model.
module tb_cache_ahb_mem_bridge;

  localparam int NT = 300;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hready;
  logic        hresp;
  logic [31:0] hrdata;
  logic [3:0]  hprot_o;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic [29:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;

  logic [31:0] mem_arr [0:255];
  logic [31:0] exp_mem [0:255];
  logic        rd_force = 1'b0;
  logic [31:0] rd_force_val = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hready_in = hready;
  assign mem_rdata = rd_force ? rd_force_val : mem_arr[mem_addr[7:0]];

  cache_ahb_mem_bridge #(.DATA_W(32), .ADDR_W(32)) dut (
    .i_hclk(clk), .i_hnreset(rst_n), .i_hsel(hsel), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hsize(hsize), .i_hburst(hburst), .i_hprot(hprot), .i_htrans(htrans), .i_hready(hready_in),
    .i_hwdata(hwdata), .o_hready(hready), .o_hresp(hresp), .o_hrdata(hrdata), .o_hprot(hprot_o),
    .i_mem_ready(mem_rdy), .i_mem_rdata(mem_rdata), .o_mem_addr(mem_addr), .o_mem_rd(mem_rd),
    .o_mem_wr(mem_wr), .o_mem_be(mem_be), .o_mem_wdata(mem_wdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'h1357_0000 ^ (i * 32'h9E37_79B9);
  endfunction

  // Memory behind the bridge: the only writer of mem_arr; commits a write when it completes.
  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (rst_n && mem_wr && mem_rdy) begin
        for (int l = 0; l < 4; l++)
          if (mem_be[l]) mem_arr[mem_addr[7:0]][l*8 +: 8] = mem_wdata[l*8 +: 8];
      end
    end
  end

  // Reference write: bytes [A, A + 2^S) that fall inside the addressed bus word take their lanes from the data.
  task automatic model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    int nb;
    int off;
    logic [31:0] w;
    nb  = 1 << s;
    off = int'(a[1:0]);
    w   = exp_mem[a[9:2]];
    for (int k = 0; k < nb; k++)
      if (off + k < 4) w[(off+k)*8 +: 8] = d[(off+k)*8 +: 8];
    exp_mem[a[9:2]] = w;
  endtask

  task automatic bus_idle();
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; haddr = '0; hsize = 3'd2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_rdy = 1'b0; bus_idle(); hburst = 3'd0; hprot = 4'h0; hwdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (hready !== 1'b1)      begin errors++; $display("FAIL rst_hready got %0h exp 1", hready); end
    checks++; if (hresp !== 1'b0)       begin errors++; $display("FAIL rst_hresp got %0h exp 0", hresp); end
    checks++; if (hrdata !== 32'h0)     begin errors++; $display("FAIL rst_hrdata got %0h exp 0", hrdata); end
    checks++; if ({mem_rd, mem_wr} !== 2'b00) begin errors++; $display("FAIL rst_strobes got %0b exp 00", {mem_rd, mem_wr}); end
    checks++; if (mem_addr !== 30'h0)   begin errors++; $display("FAIL rst_mem_addr got %0h exp 0", mem_addr); end
    checks++; if (mem_be !== 4'h0)      begin errors++; $display("FAIL rst_mem_be got %0h exp 0", mem_be); end
    checks++; if (hprot_o !== 4'h0)     begin errors++; $display("FAIL rst_hprot got %0h exp 0", hprot_o); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (hready !== 1'b1)      begin errors++; $display("FAIL rst_release_hready got %0h exp 1", hready); end
  endtask

  task automatic test_read_wait();
    rd_force = 1'b1; rd_force_val = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h100; hwrite = 1'b0; hsize = 3'd2; hprot = 4'hB; mem_rdy = 1'b0;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1)      begin errors++; $display("FAIL rd_addrph_strobe got %0h exp 1", mem_rd); end
    checks++; if (mem_addr !== 30'h40)  begin errors++; $display("FAIL rd_addrph_addr got %0h exp 40", mem_addr); end
    checks++; if (hprot_o !== 4'hB)     begin errors++; $display("FAIL rd_addrph_hprot got %0h exp b", hprot_o); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1; bus_idle(); hprot = 4'h0;
      @(negedge clk);
      checks++; if (hready !== 1'b0)    begin errors++; $display("FAIL rd_wait_hready cyc %0d got %0h exp 0", c, hready); end
      checks++; if (mem_rd !== 1'b1 || mem_addr !== 30'h40) begin errors++; $display("FAIL rd_wait_cmd cyc %0d got rd=%0h addr=%0h exp rd=1 addr=40", c, mem_rd, mem_addr); end
      checks++; if (hrdata !== 32'h0)   begin errors++; $display("FAIL rd_wait_hrdata cyc %0d got %0h exp 0", c, hrdata); end
      checks++; if (hprot_o !== 4'hB)   begin errors++; $display("FAIL rd_wait_hprot got %0h exp b", hprot_o); end
    end
    @(posedge clk); #1 mem_rdy = 1'b1;
    @(negedge clk);
    checks++; if (hready !== 1'b1)      begin errors++; $display("FAIL rd_done_hready got %0h exp 1", hready); end
    checks++; if (hrdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_done_hrdata got %0h exp deadbeef", hrdata); end
    @(posedge clk); #1 mem_rdy = 1'b0;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b0 || hrdata !== 32'h0) begin errors++; $display("FAIL rd_after got rd=%0h hrdata=%0h exp 0 0", mem_rd, hrdata); end
    rd_force = 1'b0;
  endtask

  task automatic test_byte_write();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h103; hwrite = 1'b1; hsize = 3'd0; mem_rdy = 1'b1;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL wr_addrph_strobes got wr=%0h rd=%0h exp 0 0", mem_wr, mem_rd); end
    @(posedge clk); #1; bus_idle(); hwdata = 32'hAA00_0000;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b1)      begin errors++; $display("FAIL wr_strobe got %0h exp 1", mem_wr); end
    checks++; if (mem_addr !== 30'h40)  begin errors++; $display("FAIL wr_addr got %0h exp 40", mem_addr); end
    checks++; if (mem_be !== 4'b1000)   begin errors++; $display("FAIL wr_be got %0b exp 1000", mem_be); end
    checks++; if (mem_wdata !== 32'hAA00_0000) begin errors++; $display("FAIL wr_wdata got %0h exp aa000000", mem_wdata); end
    checks++; if (hready !== 1'b1)      begin errors++; $display("FAIL wr_hready got %0h exp 1", hready); end
    model_write(32'h103, 3'd0, 32'hAA00_0000);
    @(posedge clk); #1 hwdata = '0;
    @(negedge clk);
    checks++; if (mem_wr !== 1'b0)      begin errors++; $display("FAIL wr_after_strobe got %0h exp 0", mem_wr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    mem_rdy = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h200; hsize = 3'd2;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 30'h80) begin errors++; $display("FAIL b2b_c1 got rd=%0h addr=%0h exp 1 80", mem_rd, mem_addr); end
    @(posedge clk); #1; hwrite = 1'b1; haddr = 32'h204;
    @(negedge clk);
    checks++; if (hready !== 1'b1 || mem_rd !== 1'b1 || mem_wr !== 1'b0 || mem_addr !== 30'h80)
      begin errors++; $display("FAIL b2b_c2 got rdy=%0h rd=%0h wr=%0h addr=%0h exp 1 1 0 80", hready, mem_rd, mem_wr, mem_addr); end
    checks++; if (hrdata !== exp_mem[8'h80]) begin errors++; $display("FAIL b2b_c2_hrdata got %0h exp %0h", hrdata, exp_mem[8'h80]); end
    @(posedge clk); #1; hwrite = 1'b0; haddr = 32'h208; hwdata = wd;
    @(negedge clk);
    checks++; if (hready !== 1'b1 || mem_wr !== 1'b1 || mem_rd !== 1'b0 || mem_addr !== 30'h81)
      begin errors++; $display("FAIL b2b_c3 got rdy=%0h rd=%0h wr=%0h addr=%0h exp 1 0 1 81", hready, mem_rd, mem_wr, mem_addr); end
    checks++; if (mem_be !== 4'hF || mem_wdata !== wd) begin errors++; $display("FAIL b2b_c3_data got be=%0h wdata=%0h exp f %0h", mem_be, mem_wdata, wd); end
    model_write(32'h204, 3'd2, wd);
    @(posedge clk); #1; bus_idle(); hwdata = '0;
    @(negedge clk);
    checks++; if (hready !== 1'b1 || mem_rd !== 1'b1 || mem_addr !== 30'h82)
      begin errors++; $display("FAIL b2b_c4 got rdy=%0h rd=%0h addr=%0h exp 1 1 82", hready, mem_rd, mem_addr); end
    checks++; if (hrdata !== exp_mem[8'h82]) begin errors++; $display("FAIL b2b_c4_hrdata got %0h exp %0h", hrdata, exp_mem[8'h82]); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL b2b_end got rd=%0h wr=%0h exp 0 0", mem_rd, mem_wr); end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    mem_rdy = 1'b0; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; haddr = 32'h300; hsize = 3'd2;
    @(posedge clk); #1; bus_idle();
    @(negedge clk);
    checks++; if (mem_rd !== 1'b1 || hready !== 1'b0) begin errors++; $display("FAIL rstmid_wait got rd=%0h rdy=%0h exp 1 0", mem_rd, hready); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b0)      begin errors++; $display("FAIL rstmid_drop got %0h exp 0", mem_rd); end
    checks++; if (hready !== 1'b1)      begin errors++; $display("FAIL rstmid_hready got %0h exp 1", hready); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++; if (hready !== 1'b1 || mem_rd !== 1'b0 || mem_wr !== 1'b0)
      begin errors++; $display("FAIL rstmid_after got rdy=%0h rd=%0h wr=%0h exp 1 0 0", hready, mem_rd, mem_wr); end
  endtask

  task automatic test_misaligned();
    logic [31:0] wd;
    wd = $urandom;
    @(posedge clk); #1;
    mem_rdy = 1'b1; hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h101; hsize = 3'd1;
    @(posedge clk); #1; bus_idle(); hwdata = wd;
    @(negedge clk);
`ifdef CACHE_AHB_ERR_CHECK_EN
    checks++; if (hready !== 1'b0 || hresp !== 1'b1) begin errors++; $display("FAIL err1 got rdy=%0h resp=%0h exp 0 1", hready, hresp); end
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL err1_strobes got wr=%0h rd=%0h exp 0 0", mem_wr, mem_rd); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (hready !== 1'b1 || hresp !== 1'b1) begin errors++; $display("FAIL err2 got rdy=%0h resp=%0h exp 1 1", hready, hresp); end
    checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL err2_strobes got wr=%0h rd=%0h exp 0 0", mem_wr, mem_rd); end
`else
    checks++; if (hready !== 1'b1 || hresp !== 1'b0) begin errors++; $display("FAIL mis_resp got rdy=%0h resp=%0h exp 1 0", hready, hresp); end
    checks++; if (mem_wr !== 1'b1 || mem_be !== 4'b0110) begin errors++; $display("FAIL mis_be got wr=%0h be=%0b exp 1 0110", mem_wr, mem_be); end
    model_write(32'h101, 3'd1, wd);
`endif
    @(posedge clk); #1 hwdata = '0;
    @(negedge clk);
    checks++; if (hresp !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL mis_after got resp=%0h wr=%0h exp 0 0", hresp, mem_wr); end
  endtask

  task automatic test_random_pipeline();
    logic [31:0] t_addr [NT];
    logic [31:0] t_data [NT];
    logic        t_wr   [NT];
    logic [2:0]  t_size [NT];
    logic [3:0]  t_prot [NT];
    int nxt, dph, cyc, wrd, off;
    bit pend, issue;
    for (int i = 0; i < NT; i++) begin
      t_size[i] = 3'($urandom_range(0, 2));
      wrd = $urandom_range(0, 255);
      off = (t_size[i] == 3'd2) ? 0 : (t_size[i] == 3'd1) ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
      t_addr[i] = 32'(wrd * 4 + off);
      t_wr[i]   = 1'($urandom_range(0, 1));
      t_data[i] = $urandom;
      t_prot[i] = 4'($urandom_range(0, 15));
    end
    nxt = 0; dph = -1; cyc = 0; pend = 1'b0;
    while ((nxt < NT || dph >= 0) && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      hwdata  = (dph >= 0) ? t_data[dph] : $urandom;
      mem_rdy = ($urandom_range(0, 2) != 0);
      issue   = (nxt < NT) && (pend || ($urandom_range(0, 3) != 0));
      if (issue) begin
        hsel = 1'b1; htrans = 2'b10; haddr = t_addr[nxt]; hwrite = t_wr[nxt];
        hsize = t_size[nxt]; hprot = t_prot[nxt];
      end else begin
        hsel = 1'($urandom_range(0, 1)); htrans = hsel ? 2'b00 : 2'b10;
        haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hprot = 4'($urandom_range(0, 15));
      end
      @(negedge clk);
      if (hready) begin
        if (dph >= 0) begin
          checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rnd_hresp txn %0d got %0h exp 0", dph, hresp); end
          checks++; if (hprot_o !== t_prot[dph]) begin errors++; $display("FAIL rnd_hprot txn %0d got %0h exp %0h", dph, hprot_o, t_prot[dph]); end
          if (t_wr[dph]) model_write(t_addr[dph], t_size[dph], t_data[dph]);
          else begin
            checks++;
            if (hrdata !== exp_mem[t_addr[dph][9:2]]) begin
              errors++; $display("FAIL rnd_read txn %0d addr %0h got %0h exp %0h", dph, t_addr[dph], hrdata, exp_mem[t_addr[dph][9:2]]);
            end
          end
        end
        dph  = issue ? nxt : -1;
        if (issue) nxt++;
        pend = 1'b0;
      end else begin
        pend = issue;
      end
    end
    checks++; if (cyc >= 20000) begin errors++; $display("FAIL rnd_timeout got %0d txns done exp %0d", nxt, NT); end
    @(posedge clk); #1; bus_idle(); mem_rdy = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem_arr[i] !== exp_mem[i]) begin errors++; $display("FAIL rnd_mem word %0d got %0h exp %0h", i, mem_arr[i], exp_mem[i]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = init_word(i);
    test_reset();
    test_read_wait();
    test_byte_write();
    test_back_to_back();
    test_reset_mid_read();
    test_misaligned();
    test_random_pipeline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "simulation time limit");
  end

endmodule
